// File: rtl/u712_reg_pkg.sv
// u712_reg_pkg: shared types for the chipset register bridge.
// Holds the FSM state encoding, the CPU SIZ encodings and the helper that
// turns a SIZ code into the number of chipset word cycles to run.
package u712_reg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ALIGN = 4'd1,
    ST_S2    = 4'd2,
    ST_S4    = 4'd3,
    ST_WAIT  = 4'd4,
    ST_S6    = 4'd5,
    ST_S7    = 4'd6,
    ST_NEXT  = 4'd7,
    ST_ACK   = 4'd8
  } state_t;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  // Wide enough for CPU_BYTES/CHIP_BYTES up to 4.
  localparam int SUB_W = 3;

  // Byte and word accesses need one chip cycle; long and line are both run
  // as a single long, split into as many words as the CPU bus carries.
  function automatic logic [SUB_W-1:0] sub_cycles(input logic [1:0] siz,
                                                  input int cpu_bytes,
                                                  input int chip_bytes);
    logic [SUB_W-1:0] n;
    if (siz == SIZ_BYTE || siz == SIZ_WORD) n = SUB_W'(1);
    else                                    n = SUB_W'(cpu_bytes / chip_bytes);
    return n;
  endfunction

endpackage

// File: rtl/u712_chip_reg_bridge_if.sv
// u712_chip_reg_bridge_if: CPU-side and chipset-side signals of the register bridge.
// Handshake: nTS is a one-cycle start request, honoured only when the bridge
// is idle (REG_CYCLE low) and nREGSPACE is low in the same cycle; there is no
// backpressure, a request while busy is dropped. Completion is a one-cycle
// REG_TA pulse (REG_TBI qualifies it) or, with the timeout build, a one-cycle
// nTEA pulse; exactly one of the two ends every accepted request, except when
// reset aborts the transfer.
interface u712_chip_reg_bridge_if;
  logic       C1;
  logic       C3;
  logic       nDBR;
  logic       nTS;
  logic       nREGSPACE;
  logic       RnW;
  logic [1:0] SIZ;
  logic [1:0] A;
  logic       nAS;
  logic       nUDS;
  logic       nLDS;
  logic       nREGEN;
  logic       LATCH_HI;
  logic       LATCH_EN;
  logic       REG_TA;
  logic       REG_TBI;
  logic       REG_CYCLE;
  logic       nTEA;

  modport master (
    output C1, C3, nDBR, nTS, nREGSPACE, RnW, SIZ, A,
    input  nAS, nUDS, nLDS, nREGEN, LATCH_HI, LATCH_EN, REG_TA, REG_TBI, REG_CYCLE, nTEA
  );

  modport slave (
    input  C1, C3, nDBR, nTS, nREGSPACE, RnW, SIZ, A,
    output nAS, nUDS, nLDS, nREGEN, LATCH_HI, LATCH_EN, REG_TA, REG_TBI, REG_CYCLE, nTEA
  );
endinterface

// File: rtl/u712_phase_sync.sv
// u712_phase_sync: brings the Agnus C1/C3 phase clocks and nDBR into the
// CLK40 domain and derives one-cycle phase strobes from C1. C3 only qualifies
// the C1 edges (low at a genuine C1 rise, high at a genuine C1 fall), which
// rejects glitches on C1 that do not fit the quadrature pattern.
module u712_phase_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic c1,
  input  logic c3,
  input  logic n_dbr,
  output logic ph_r,
  output logic ph_f,
  output logic n_dbr_s
);

  logic [SYNC_STAGES-1:0] c1_sync;
  logic [SYNC_STAGES-1:0] c3_sync;
  logic [SYNC_STAGES-1:0] dbr_sync;
  logic                   c1_d;

  // Multi-stage synchronisers plus one history flop for C1 edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1_sync  <= '0;
      c3_sync  <= '0;
      dbr_sync <= '1;
      c1_d     <= 1'b0;
    end else begin
      c1_sync  <= {c1_sync[SYNC_STAGES-2:0], c1};
      c3_sync  <= {c3_sync[SYNC_STAGES-2:0], c3};
      dbr_sync <= {dbr_sync[SYNC_STAGES-2:0], n_dbr};
      c1_d     <= c1_sync[SYNC_STAGES-1];
    end
  end

  assign ph_r    =  c1_sync[SYNC_STAGES-1] & ~c1_d & ~c3_sync[SYNC_STAGES-1];
  assign ph_f    = ~c1_sync[SYNC_STAGES-1] &  c1_d &  c3_sync[SYNC_STAGES-1];
  assign n_dbr_s =  dbr_sync[SYNC_STAGES-1];

endmodule

// File: rtl/u712_chip_reg_bridge.sv
// u712_chip_reg_bridge: turns one CPU register-space access into a sequence
// of 68000-style word cycles on the chipset register port, locked to C1.
// Optional feature macro: U712_REG_TIMEOUT_EN adds a bus-error timeout in
// ALIGN/WAIT that ends the access with an nTEA pulse instead of REG_TA.
module u712_chip_reg_bridge
  import u712_reg_pkg::*;
#(
  parameter int CPU_BYTES   = 4,
  parameter int CHIP_BYTES  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                    CLK40,
  input  logic                    nRESET,
  u712_chip_reg_bridge_if.slave   bus,
  output state_t                  dbg_state
);

  // Elaboration-time parameter sanity checks.
  if (CPU_BYTES != 4 && CPU_BYTES != 8) begin : g_bad_cpu_bytes
    $error("CPU_BYTES must be 4 or 8");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be 2 or 3");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  logic ph_r;
  logic ph_f;
  logic dbr_n_s;

  u712_phase_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (CLK40),
    .rst_n   (nRESET),
    .c1      (bus.C1),
    .c3      (bus.C3),
    .n_dbr   (bus.nDBR),
    .ph_r    (ph_r),
    .ph_f    (ph_f),
    .n_dbr_s (dbr_n_s)
  );

  state_t           state;
  logic             rnw_q;
  logic [1:0]       siz_q;
  logic [SUB_W-1:0] left;
  logic             use_uds;
  logic             use_lds;
  logic             n_as;
  logic             n_uds;
  logic             n_lds;
  logic             n_regen;
  logic             n_tea;
  logic             latch_hi;
  logic             latch_en;
  logic             reg_ta;
  logic             reg_tbi;
  logic             reg_cycle;

`ifdef U712_REG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt;
`endif

  // Start-time decode of the access: narrow accesses pick strobes and word
  // half from the address, long/line always run both strobes, high word first.
  logic start;
  logic narrow;
  logic is_byte;
  assign start   = ~bus.nTS & ~bus.nREGSPACE;
  assign is_byte = (bus.SIZ == SIZ_BYTE);
  assign narrow  = is_byte | (bus.SIZ == SIZ_WORD);

  // Word-cycle sequencer: every output is a register so the strobes are clean.
  always_ff @(posedge CLK40 or negedge nRESET) begin
    if (!nRESET) begin
      state     <= ST_IDLE;
      rnw_q     <= 1'b1;
      siz_q     <= SIZ_LONG;
      left      <= '0;
      use_uds   <= 1'b0;
      use_lds   <= 1'b0;
      n_as      <= 1'b1;
      n_uds     <= 1'b1;
      n_lds     <= 1'b1;
      n_regen   <= 1'b1;
      n_tea     <= 1'b1;
      latch_hi  <= 1'b0;
      latch_en  <= 1'b0;
      reg_ta    <= 1'b0;
      reg_tbi   <= 1'b0;
      reg_cycle <= 1'b0;
`ifdef U712_REG_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      latch_en <= 1'b0;
      reg_ta   <= 1'b0;
      reg_tbi  <= 1'b0;
      n_tea    <= 1'b1;
      case (state)
        ST_IDLE: begin
          reg_cycle <= 1'b0;
          if (start) begin
            reg_cycle <= 1'b1;
            rnw_q     <= bus.RnW;
            siz_q     <= bus.SIZ;
            left      <= sub_cycles(bus.SIZ, CPU_BYTES, CHIP_BYTES);
            latch_hi  <= narrow ? ~bus.A[1] : 1'b1;
            use_uds   <= is_byte ? ~bus.A[0] : 1'b1;
            use_lds   <= is_byte ?  bus.A[0] : 1'b1;
            state     <= ST_ALIGN;
          end
        end
        // This PH_R is S0; the bus is only claimed if Agnus is not requesting.
        ST_ALIGN: if (ph_r && dbr_n_s) state <= ST_S2;
        ST_S2: if (ph_r) begin
          n_as    <= 1'b0;
          n_regen <= 1'b0;
          if (rnw_q) begin
            n_uds <= ~use_uds;
            n_lds <= ~use_lds;
          end
          state <= ST_S4;
        end
        ST_S4: if (ph_r) begin
          if (!rnw_q) begin
            n_uds <= ~use_uds;
            n_lds <= ~use_lds;
          end
          state <= ST_WAIT;
        end
        ST_WAIT: if (dbr_n_s) state <= ST_S6;
        ST_S6: if (ph_r) begin
          latch_en <= rnw_q;
          state    <= ST_S7;
        end
        ST_S7: if (ph_f) begin
          n_as    <= 1'b1;
          n_uds   <= 1'b1;
          n_lds   <= 1'b1;
          n_regen <= 1'b1;
          state   <= ST_NEXT;
        end
        ST_NEXT: begin
          if (left > SUB_W'(1)) begin
            left     <= left - SUB_W'(1);
            latch_hi <= ~latch_hi;
            state    <= ST_ALIGN;
          end else begin
            state <= ST_ACK;
          end
        end
        ST_ACK: begin
          reg_ta  <= 1'b1;
          reg_tbi <= (siz_q == SIZ_LINE);
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
`ifdef U712_REG_TIMEOUT_EN
      // Counter is zero on every entry to ALIGN/WAIT because it is held
      // clear in all other states; expiry overrides the normal transition.
      if (state == ST_ALIGN || state == ST_WAIT) begin
        if (to_cnt == TO_LAST) begin
          n_as    <= 1'b1;
          n_uds   <= 1'b1;
          n_lds   <= 1'b1;
          n_regen <= 1'b1;
          n_tea   <= 1'b0;
          left    <= '0;
          state   <= ST_IDLE;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end else begin
        to_cnt <= '0;
      end
`endif
    end
  end

  assign bus.nAS       = n_as;
  assign bus.nUDS      = n_uds;
  assign bus.nLDS      = n_lds;
  assign bus.nREGEN    = n_regen;
  assign bus.LATCH_HI  = latch_hi;
  assign bus.LATCH_EN  = latch_en;
  assign bus.REG_TA    = reg_ta;
  assign bus.REG_TBI   = reg_tbi;
  assign bus.REG_CYCLE = reg_cycle;
  assign bus.nTEA      = n_tea;
  assign dbg_state     = state;

endmodule

// File: tb/tb_u712_chip_reg_bridge.sv
// tb_u712_chip_reg_bridge: directed bench for the chipset register bridge.
// C1 period is 16 CLK40 cycles, C3 lags C1 by a quarter period, and the
// phase clocks are offset from CLK40 so their edges never coincide.
module tb_u712_chip_reg_bridge;
  import u712_reg_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     total = 0;
  int     bad   = 0;

  u712_chip_reg_bridge_if bus();

  u712_chip_reg_bridge #(
    .CPU_BYTES   (4),
    .CHIP_BYTES  (2),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (64)
  ) dut (
    .CLK40     (clk),
    .nRESET    (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and phase-clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    bus.C1 = 1'b0;
    bus.C3 = 1'b0;
    #3;
    forever begin
      bus.C1 = 1'b1; #40;
      bus.C3 = 1'b1; #40;
      bus.C1 = 1'b0; #40;
      bus.C3 = 1'b0; #40;
    end
  end

  // Bus monitor, sampled on the falling clock edge.
  int       as_falls, le_cnt, ta_cnt, tea_cnt;
  int       since_rise = 0, since_wait = 0, ta_lat = 0, tea_lat = 0;
  int       regen_bad = 0, strobe_bad = 0, cyc_bad = 0;
  logic [3:0] hi_seq;
  logic [1:0] str_at_as;
  logic     uds_seen, lds_seen, tbi_at_ta;
  logic     prev_nas = 1'b1;
  state_t   prev_state = ST_IDLE;

  always @(negedge clk) begin
    if (prev_nas && !bus.nAS) begin
      if (as_falls < 4) hi_seq[as_falls[1:0]] = bus.LATCH_HI;
      if (as_falls == 0) str_at_as = {bus.nUDS, bus.nLDS};
      as_falls++;
    end
    if (!prev_nas && bus.nAS) since_rise = 0;
    else                      since_rise++;
    if (dbg_state == ST_WAIT && prev_state != ST_WAIT) since_wait = 0;
    else                                               since_wait++;
    if (!bus.nUDS) uds_seen = 1'b1;
    if (!bus.nLDS) lds_seen = 1'b1;
    if (bus.LATCH_EN) le_cnt++;
    if (bus.REG_TA) begin
      ta_cnt++;
      ta_lat    = since_rise;
      tbi_at_ta = bus.REG_TBI;
      if (!bus.REG_CYCLE) cyc_bad++;
    end
    if (!bus.nTEA) begin
      tea_cnt++;
      tea_lat = since_wait;
    end
    if (bus.nREGEN !== bus.nAS) regen_bad++;
    if ((!bus.nUDS || !bus.nLDS) && bus.nAS) strobe_bad++;
    prev_nas   = bus.nAS;
    prev_state = dbg_state;
  end

  // Comparison helper.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    as_falls  = 0;
    le_cnt    = 0;
    ta_cnt    = 0;
    tea_cnt   = 0;
    hi_seq    = 4'h0;
    str_at_as = 2'b11;
    uds_seen  = 1'b0;
    lds_seen  = 1'b0;
    tbi_at_ta = 1'b0;
  endtask

  task automatic start_access(input logic rnw, input logic [1:0] siz, input logic [1:0] a);
    @(posedge clk); #1;
    bus.nTS       = 1'b0;
    bus.nREGSPACE = 1'b0;
    bus.RnW       = rnw;
    bus.SIZ       = siz;
    bus.A         = a;
    @(posedge clk); #1;
    bus.nTS       = 1'b1;
    bus.nREGSPACE = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (ta_cnt + tea_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, (ta_cnt + tea_cnt > 0), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_state(input string tag, input state_t target, input int budget);
    int n = 0;
    while (dbg_state != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, (dbg_state == target), 1);
  endtask

  // Directed stimulus and checks.
  initial begin
    rst_n         = 1'b0;
    bus.nTS       = 1'b1;
    bus.nREGSPACE = 1'b1;
    bus.RnW       = 1'b1;
    bus.SIZ       = SIZ_LONG;
    bus.A         = 2'b00;
    bus.nDBR      = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_outputs", {bus.nAS, bus.nUDS, bus.nLDS, bus.nREGEN, bus.nTEA,
                          bus.LATCH_HI, bus.LATCH_EN, bus.REG_TA, bus.REG_TBI, bus.REG_CYCLE},
          10'b11111_00000);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // nTS without register-space select is not a register access.
    @(posedge clk); #1;
    bus.nTS = 1'b0;
    @(posedge clk); #1;
    bus.nTS = 1'b1;
    repeat (4) @(negedge clk);
    check("nosel_cycle", bus.REG_CYCLE, 0);
    check("nosel_state", dbg_state, ST_IDLE);

    // Byte write, A=01: one cycle on nLDS only.
    clear_mon();
    start_access(1'b0, SIZ_BYTE, 2'b01);
    check("bw_cycle", bus.REG_CYCLE, 1);
    wait_done("bw_done", 1000);
    check("bw_ta", ta_cnt, 1);
    check("bw_tea", tea_cnt, 0);
    check("bw_as_falls", as_falls, 1);
    check("bw_uds_low", uds_seen, 0);
    check("bw_lds_low", lds_seen, 1);
    check("bw_tbi", tbi_at_ta, 0);
    check("bw_latch_en", le_cnt, 0);
    check("bw_ta_latency", ta_lat, 2);
    check("bw_strobes_at_as", str_at_as, 2'b11);
    check("bw_latch_hi", hi_seq[0], 1);
    check("bw_cycle_end", bus.REG_CYCLE, 0);

    // Long read: two word cycles, high word first.
    clear_mon();
    start_access(1'b1, SIZ_LONG, 2'b00);
    wait_done("lr_done", 1000);
    check("lr_as_falls", as_falls, 2);
    check("lr_latch_hi_seq", {hi_seq[0], hi_seq[1]}, 2'b10);
    check("lr_latch_en", le_cnt, 2);
    check("lr_ta", ta_cnt, 1);
    check("lr_ta_latency", ta_lat, 2);
    check("lr_tbi", tbi_at_ta, 0);
    check("lr_strobes_at_as", str_at_as, 2'b00);
    check("lr_both_strobes", {uds_seen, lds_seen}, 2'b11);

    // Line read: run as one long, burst inhibit with the ack.
    clear_mon();
    start_access(1'b1, SIZ_LINE, 2'b00);
    wait_done("ln_done", 1000);
    check("ln_as_falls", as_falls, 2);
    check("ln_ta", ta_cnt, 1);
    check("ln_tbi", tbi_at_ta, 1);

    // Word write to the low half.
    clear_mon();
    start_access(1'b0, SIZ_WORD, 2'b10);
    wait_done("ww_done", 1000);
    check("ww_as_falls", as_falls, 1);
    check("ww_latch_hi", hi_seq[0], 0);
    check("ww_both_strobes", {uds_seen, lds_seen}, 2'b11);
    check("ww_strobes_at_as", str_at_as, 2'b11);
    check("ww_ta", ta_cnt, 1);

    // Byte read, A=00: nUDS only, one capture pulse.
    clear_mon();
    start_access(1'b1, SIZ_BYTE, 2'b00);
    wait_done("br_done", 1000);
    check("br_strobes", {uds_seen, lds_seen}, 2'b10);
    check("br_strobes_at_as", str_at_as, 2'b01);
    check("br_latch_en", le_cnt, 1);
    check("br_ta", ta_cnt, 1);

`ifndef U712_REG_TIMEOUT_EN
    // Agnus holds the bus for 40 C1 periods; a second nTS meanwhile is dropped.
    bus.nDBR = 1'b0;
    repeat (4) @(negedge clk);
    clear_mon();
    start_access(1'b0, SIZ_BYTE, 2'b01);
    repeat (10) @(negedge clk);
    start_access(1'b1, SIZ_WORD, 2'b00);
    repeat (40 * 16) @(negedge clk);
    check("dbr_as_held", as_falls, 0);
    check("dbr_state", dbg_state, ST_ALIGN);
    check("dbr_cycle", bus.REG_CYCLE, 1);
    bus.nDBR = 1'b1;
    wait_done("dbr_done", 1000);
    check("dbr_ta", ta_cnt, 1);
    check("dbr_as_falls", as_falls, 1);
    check("dbr_strobes", {uds_seen, lds_seen}, 2'b01);
    check("dbr_latch_en", le_cnt, 0);
    repeat (100) @(negedge clk);
    check("dbr_no_extra_ta", ta_cnt, 1);
`else
    // nDBR stuck low in WAIT: bus error after the timeout, no ack.
    clear_mon();
    start_access(1'b1, SIZ_WORD, 2'b00);
    wait_state("to_reach_s4", ST_S4, 500);
    bus.nDBR = 1'b0;
    wait_done("to_done", 1000);
    check("to_tea", tea_cnt, 1);
    check("to_ta", ta_cnt, 0);
    check("to_latency", tea_lat, 64);
    check("to_state", dbg_state, ST_IDLE);
    check("to_cycle", bus.REG_CYCLE, 0);
    check("to_strobes", {bus.nAS, bus.nUDS, bus.nLDS, bus.nREGEN}, 4'hf);
    bus.nDBR = 1'b1;
    repeat (4) @(negedge clk);
`endif

    // Reset in the middle of a long write, strobes low.
    clear_mon();
    start_access(1'b0, SIZ_LONG, 2'b00);
    wait_state("rm_reach_s6", ST_S6, 500);
    #2;
    check("rm_strobes_low", {bus.nAS, bus.nUDS, bus.nLDS, bus.nREGEN}, 4'h0);
    rst_n = 1'b0;
    #1;
    check("rm_strobes_async", {bus.nAS, bus.nUDS, bus.nLDS, bus.nREGEN}, 4'hf);
    check("rm_cycle_async", bus.REG_CYCLE, 0);
    repeat (20) @(negedge clk);
    check("rm_no_ta", ta_cnt, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    clear_mon();
    start_access(1'b0, SIZ_BYTE, 2'b00);
    wait_done("rm_next_done", 1000);
    check("rm_next_ta", ta_cnt, 1);
    check("rm_next_strobes", {uds_seen, lds_seen}, 2'b10);

    // Whole-run invariants.
    check("regen_tracks_as", regen_bad, 0);
    check("strobes_inside_as", strobe_bad, 0);
    check("ta_inside_cycle", cyc_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
